layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Top-level sequencer that runs a programmed list of layers through the computation engines. It reads per-layer type codes from the register file, drives `comp_sel` and a start pulse toward the computation controller, and waits for the active engine's completion. It toggles the ping-pong buffer role between layers and reports overall progress and completion to the host. It sits above the computation controller as the initiator of its `comp_sel`/start/done protocol.

## Interface
Parameters:
- `MAX_LAYERS`, 16: maximum layers per run.
- `IDX_W`, 4: layer index width; must satisfy 2^IDX_W >= MAX_LAYERS.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored unless in IDLE.
- `abort`  in  1  level; forces return to IDLE.
- `num_layers`  in  IDX_W+1  layer count; sampled on `start`.
- `layer_idx`  out  IDX_W  descriptor index being fetched or run.
- `layer_type`  in  3  regfile type code for `layer_idx`; combinational, valid in the same cycle.
- `comp_sel`  out  3  engine select: 000 none, 001 conv, 010 dense, 011 pool.
- `eng_start`  out  1  one-cycle pulse to the selected engine.
- `eng_done`  in  1  one-cycle pulse from the selected engine.
- `buf_swap`  out  1  ping-pong role bit; 0 = buf1 input/buf2 output, 1 = swapped.
- `busy`  out  1  high in any state other than IDLE.
- `run_done`  out  1  one-cycle pulse when all layers complete.
- `err`  out  1  sticky illegal-type flag; cleared by the next accepted `start`.

## Operation
States are IDLE, FETCH, LAUNCH, RUN, NEXT and ERR.

- **IDLE:** `comp_sel`=000 and `busy`=0.
  - `start` with `num_layers` = 0 pulses `run_done` next cycle and stays in IDLE.
  - `start` with `num_layers` > MAX_LAYERS sets `err` and goes to ERR.
  - Any other `start` latches the count, clears `layer_idx`, `buf_swap` and `err`, and goes to FETCH.
- **FETCH:** samples `layer_type` into a type register.
  - Codes 001, 010 and 011 go to LAUNCH.
  - Any other code sets `err` and goes to ERR.
- **LAUNCH:** drives `comp_sel` from the type register, asserts `eng_start` for this one cycle, then goes to RUN.
- **RUN:** holds `comp_sel`. Waits for `eng_done`, then goes to NEXT.
- **NEXT:** `comp_sel`=000, giving one idle cycle between engines.
  - If `layer_idx` = count−1, pulse `run_done` and go to IDLE.
  - Otherwise increment `layer_idx`, toggle `buf_swap`, and go to FETCH.
  - `buf_swap` is not toggled after the last layer.
- **ERR:** `comp_sel`=000, `busy`=1. Exits to IDLE only on `abort`.
- **`abort`:** in any state, goes to IDLE the next cycle with `comp_sel`=000. It does not pulse `run_done` and does not clear `err`.
- **Simultaneous events:**
  - `abort` has priority over `eng_done` and `start`.
  - `start` outside IDLE is ignored.
  - `eng_done` outside RUN is ignored; it is not counted and not stored.
- **Width rule:** the count comparison is done at IDX_W+1 bits, so count = MAX_LAYERS is legal.

## Timing
- **Reset values:** state IDLE, `layer_idx`=0, `comp_sel`=000, `eng_start`=0, `buf_swap`=0, `busy`=0, `run_done`=0, `err`=0. All outputs are registered.
- **Start latency:** `start` at cycle T gives FETCH at T+1 and `eng_start` with valid `comp_sel` at T+2.
- **Per-layer overhead:** 3 cycles (FETCH, LAUNCH, NEXT) plus engine runtime.
  - `eng_done` at cycle D gives NEXT at D+1.
  - The next layer's `eng_start` comes at D+3.
  - For the last layer, `run_done` comes at D+2.
- **Reset mid-run:** asynchronous `rst` asserted during RUN immediately forces `comp_sel`=000 and `busy`=0. Any later `eng_done` is ignored.

## Test plan
- **Three-layer run:** `num_layers`=3, types conv/pool/dense, `eng_done` 10 cycles after each `eng_start`.
  - Expect `comp_sel` sequence 001, 011, 010, each separated by a 000 cycle.
  - Expect `buf_swap` 0, 1, 0 for the three layers.
  - Expect exactly one `run_done`, at 2 cycles after the third `eng_done`, and `busy` low after it.
- **Zero and oversized counts:**
  - `num_layers`=0: `run_done` one cycle after `start`; `eng_start` never asserted.
  - `num_layers`=17: `err`=1, state ERR, `comp_sel`=000.
- **Illegal type:** layer 1 type = 101.
  - Layer 0 completes normally, then `err`=1 and `comp_sel` stays 000.
  - `abort` returns to IDLE with `err` still 1; the next valid `start` clears it.
- **Abort during RUN plus stray done:** `abort` asserted in the same cycle as `eng_done`.
  - Expect IDLE next cycle and no `run_done`.
  - An `eng_done` pulse while in IDLE causes no state change.
- **Async reset mid-run:** `rst` low during layer 2 of 4.
  - Expect all outputs at reset values with no clock edge required.
  - After release, a fresh 4-layer run completes with `layer_idx` 0 through 3.
- **Full-length run:** `num_layers`=16, all conv, `eng_done` 1 cycle after `eng_start`.
  - Expect 16 `eng_start` pulses, `layer_idx` reaching 15 without wrap, and `buf_swap`=1 on layer 15.

Source files
------------

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// layer_sequencer_if
// Engine-select handshake between the layer sequencer and the computation
// controller: comp_sel/eng_start forward, eng_done back.
// Revision: 1.0
// ============================================================================
interface layer_sequencer_if;
  logic [2:0] comp_sel;
  logic       eng_start;
  logic       eng_done;

  modport master (
    output comp_sel,
    output eng_start,
    input  eng_done
  );

  modport slave (
    input  comp_sel,
    input  eng_start,
    output eng_done
  );
endinterface
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// layer_sequencer
// Walks a programmed layer list, launches one engine per layer and reports
// progress and completion to the host.
// Revision: 1.0
// ============================================================================
module layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int IDX_W      = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             abort,
  input  wire logic [IDX_W:0]   num_layers,
  output logic      [IDX_W-1:0] layer_idx,
  input  wire logic [2:0]       layer_type,
  output logic                  buf_swap,
  output logic                  busy,
  output logic                  run_done,
  output logic                  err,
  layer_sequencer_if.master     eng
);

  localparam logic [IDX_W:0]   C_MAX     = (IDX_W+1)'(MAX_LAYERS);
  localparam logic [IDX_W:0]   C_CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);
  localparam logic [2:0]       C_SEL_NONE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t           r_state,     w_state_d;
  logic [IDX_W-1:0] r_idx,       w_idx_d;
  logic [IDX_W:0]   r_count,     w_count_d;
  logic [2:0]       r_type,      w_type_d;
  logic             r_swap,      w_swap_d;
  logic             r_err,       w_err_d;
  logic             r_run_done,  w_run_done_d;
  logic [2:0]       r_comp_sel,  w_comp_sel_d;
  logic             r_eng_start, w_eng_start_d;
  logic             r_busy,      w_busy_d;
  logic             w_last;
  logic             w_type_ok;

  // Compare at IDX_W+1 bits so that a count of exactly MAX_LAYERS is reachable.
  assign w_last    = ({1'b0, r_idx} == (r_count - C_CNT_ONE));
  assign w_type_ok = (layer_type == 3'b001) || (layer_type == 3'b010) ||
                     (layer_type == 3'b011);

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_count_d    = r_count;
    w_type_d     = r_type;
    w_swap_d     = r_swap;
    w_err_d      = r_err;
    w_run_done_d = 1'b0;

    if (abort) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_layers == '0) begin
              w_run_done_d = 1'b1;
            end else if (num_layers > C_MAX) begin
              w_err_d   = 1'b1;
              w_state_d = S_ERR;
            end else begin
              w_count_d = num_layers;
              w_idx_d   = '0;
              w_swap_d  = 1'b0;
              w_err_d   = 1'b0;
              w_state_d = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          w_type_d = layer_type;
          if (w_type_ok) begin
            w_state_d = S_LAUNCH;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = S_ERR;
          end
        end
        S_LAUNCH: begin
          w_state_d = S_RUN;
        end
        S_RUN: begin
          if (eng.eng_done) begin
            w_state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            w_run_done_d = 1'b1;
            w_state_d    = S_IDLE;
          end else begin
            w_idx_d   = r_idx + C_IDX_ONE;
            w_swap_d  = ~r_swap;
            w_state_d = S_FETCH;
          end
        end
        S_ERR: begin
          w_state_d = S_ERR;
        end
        default: begin
          w_state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    w_comp_sel_d  = ((w_state_d == S_LAUNCH) || (w_state_d == S_RUN)) ? w_type_d : C_SEL_NONE;
    w_eng_start_d = (w_state_d == S_LAUNCH);
    w_busy_d      = (w_state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_count     <= '0;
      r_type      <= C_SEL_NONE;
      r_swap      <= 1'b0;
      r_err       <= 1'b0;
      r_run_done  <= 1'b0;
      r_comp_sel  <= C_SEL_NONE;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_count     <= w_count_d;
      r_type      <= w_type_d;
      r_swap      <= w_swap_d;
      r_err       <= w_err_d;
      r_run_done  <= w_run_done_d;
      r_comp_sel  <= w_comp_sel_d;
      r_eng_start <= w_eng_start_d;
      r_busy      <= w_busy_d;
    end
  end

  assign layer_idx     = r_idx;
  assign buf_swap      = r_swap;
  assign busy          = r_busy;
  assign run_done      = r_run_done;
  assign err           = r_err;
  assign eng.comp_sel  = r_comp_sel;
  assign eng.eng_start = r_eng_start;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_layer_sequencer
// Self-checking bench: vector table, scripted corner cases and randomized
// runs checked against an event-timeline model of the sequencer.
// Revision: 1.0
// ============================================================================
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] num_layers = '0;
  logic [3:0] layer_idx;
  logic [2:0] layer_type;
  logic       buf_swap, busy, run_done, err;

  logic [2:0] types_arr [16];
  int         dly_arr   [16];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  layer_sequencer_if eng_bus ();

  layer_sequencer #(.MAX_LAYERS(16), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_layers (num_layers),
    .layer_idx  (layer_idx),
    .layer_type (layer_type),
    .buf_swap   (buf_swap),
    .busy       (busy),
    .run_done   (run_done),
    .err        (err),
    .eng        (eng_bus)
  );

  // Register file: type code is combinational on the requested index.
  assign layer_type = types_arr[layer_idx];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: first eng_start 2 cycles after start, each later one
  // 3 cycles after the previous eng_done, run_done 2 cycles after the last.
  task automatic run_layers(input int n, input bit stray);
    int  k, t0, pend, exp_st, exp_rd, limit;
    bit  fin;
    k = 0; pend = -10; exp_rd = -1; fin = 1'b0;
    num_layers = 5'(n);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    exp_st = t0 + 2;
    limit  = n * 16 + 20;
    for (int c = 0; c < limit && !fin; c++) begin
      eng_bus.eng_done = 1'b0;
      if (eng_bus.eng_start) begin
        chk("start_time", cyc, exp_st);
        chk("sel", int'(eng_bus.comp_sel), int'(types_arr[k]));
        chk("swap", int'(buf_swap), k % 2);
        chk("idx", int'(layer_idx), k);
        pend = cyc + dly_arr[k];
        k++;
        if (stray) eng_bus.eng_done = 1'b1;
      end else if (cyc == pend) begin
        eng_bus.eng_done = 1'b1;
        if (k == n) exp_rd = cyc + 2;
        else        exp_st = cyc + 3;
      end else if (cyc == pend + 1) begin
        chk("gap_sel", int'(eng_bus.comp_sel), 0);
      end
      if (run_done) begin
        chk("run_done_time", cyc, exp_rd);
        chk("layers_launched", k, n);
        chk("busy_after_done", int'(busy), 0);
        fin = 1'b1;
      end
      if (!fin) tick();
    end
    eng_bus.eng_done = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no run_done expected one within %0d cycles", limit);
    end
  endtask

  typedef struct {
    bit st; bit ab; int num; int lt; bit dn;
    int e_busy; int e_sel; int e_es; int e_rd; int e_err; int e_idx; int e_swap;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int rd_seen;
    for (int i = 0; i < 16; i++) begin
      types_arr[i] = 3'b001;
      dly_arr[i]   = 1;
    end
    eng_bus.eng_done = 1'b0;

    //            st ab num lt dn   busy sel es rd err idx swap
    tbl[0]  = '{0, 0, 0,  1, 0,   0,   0,  0, 0, 0,  0,  0};
    tbl[1]  = '{1, 0, 1,  3, 0,   1,   0,  0, 0, 0,  0,  0};
    tbl[2]  = '{0, 0, 0,  3, 0,   1,   3,  1, 0, 0,  0,  0};
    tbl[3]  = '{0, 0, 0,  3, 1,   1,   3,  0, 0, 0,  0,  0};
    tbl[4]  = '{0, 0, 0,  3, 0,   1,   3,  0, 0, 0,  0,  0};
    tbl[5]  = '{0, 0, 0,  3, 1,   1,   0,  0, 0, 0,  0,  0};
    tbl[6]  = '{0, 0, 0,  3, 0,   0,   0,  0, 1, 0,  0,  0};
    tbl[7]  = '{0, 0, 0,  3, 0,   0,   0,  0, 0, 0,  0,  0};
    tbl[8]  = '{1, 0, 0,  3, 0,   0,   0,  0, 1, 0,  0,  0};
    tbl[9]  = '{0, 0, 0,  3, 0,   0,   0,  0, 0, 0,  0,  0};
    tbl[10] = '{1, 0, 17, 3, 0,   1,   0,  0, 0, 1,  0,  0};
    tbl[11] = '{1, 0, 1,  3, 0,   1,   0,  0, 0, 1,  0,  0};
    tbl[12] = '{0, 1, 0,  3, 0,   0,   0,  0, 0, 1,  0,  0};
    tbl[13] = '{1, 0, 16, 1, 0,   1,   0,  0, 0, 0,  0,  0};
    tbl[14] = '{1, 1, 2,  1, 0,   0,   0,  0, 0, 0,  0,  0};
    tbl[15] = '{1, 1, 2,  1, 0,   0,   0,  0, 0, 0,  0,  0};
    tbl[16] = '{1, 0, 1,  2, 0,   1,   0,  0, 0, 0,  0,  0};
    tbl[17] = '{0, 0, 0,  2, 0,   1,   2,  1, 0, 0,  0,  0};
    tbl[18] = '{0, 1, 0,  2, 1,   0,   0,  0, 0, 0,  0,  0};

    // Reset values while rst is held low.
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(eng_bus.comp_sel), 0);
    chk("rst_es", int'(eng_bus.eng_start), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      start            = tbl[i].st;
      abort            = tbl[i].ab;
      num_layers       = 5'(tbl[i].num);
      types_arr[0]     = 3'(tbl[i].lt);
      eng_bus.eng_done = tbl[i].dn;
      tick();
      chk($sformatf("v%0d_busy", i), int'(busy), tbl[i].e_busy);
      chk($sformatf("v%0d_sel", i), int'(eng_bus.comp_sel), tbl[i].e_sel);
      chk($sformatf("v%0d_es", i), int'(eng_bus.eng_start), tbl[i].e_es);
      chk($sformatf("v%0d_rd", i), int'(run_done), tbl[i].e_rd);
      chk($sformatf("v%0d_err", i), int'(err), tbl[i].e_err);
      chk($sformatf("v%0d_idx", i), int'(layer_idx), tbl[i].e_idx);
      chk($sformatf("v%0d_swap", i), int'(buf_swap), tbl[i].e_swap);
    end
    start = 1'b0; abort = 1'b0; eng_bus.eng_done = 1'b0;
    tick();

    // Three-layer run: conv, pool, dense, done 10 cycles after each start.
    types_arr[0] = 3'b001; types_arr[1] = 3'b011; types_arr[2] = 3'b010;
    for (int i = 0; i < 3; i++) dly_arr[i] = 10;
    run_layers(3, 1'b0);
    tick();

    // Illegal type on layer 1.
    types_arr[0] = 3'b001; types_arr[1] = 3'b101;
    num_layers = 5'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("ill_es0", int'(eng_bus.eng_start), 1);
    tick(); eng_bus.eng_done = 1'b1;
    tick(); eng_bus.eng_done = 1'b0;
    chk("ill_next_sel", int'(eng_bus.comp_sel), 0);
    tick();
    chk("ill_fetch_idx", int'(layer_idx), 1);
    tick();
    chk("ill_err", int'(err), 1);
    chk("ill_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_hold_sel", int'(eng_bus.comp_sel), 0);
      chk("ill_hold_es", int'(eng_bus.eng_start), 0);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ill_abort_busy", int'(busy), 0);
    chk("ill_abort_err", int'(err), 1);
    types_arr[0] = 3'b010; num_layers = 5'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("ill_restart_err", int'(err), 0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort coinciding with eng_done in RUN, then stray done in IDLE.
    types_arr[0] = 3'b001; types_arr[1] = 3'b011;
    num_layers = 5'd2; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("ab_run_sel", int'(eng_bus.comp_sel), 1);
    abort = 1'b1; eng_bus.eng_done = 1'b1;
    tick(); abort = 1'b0; eng_bus.eng_done = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_sel", int'(eng_bus.comp_sel), 0);
    rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (run_done) rd_seen++;
    end
    chk("ab_no_run_done", rd_seen, 0);
    eng_bus.eng_done = 1'b1; tick(); eng_bus.eng_done = 1'b0;
    tick();
    chk("stray_busy", int'(busy), 0);
    chk("stray_idx", int'(layer_idx), 0);

    // Asynchronous reset during layer 2 of 4.
    for (int i = 0; i < 4; i++) types_arr[i] = 3'b010;
    num_layers = 5'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); eng_bus.eng_done = 1'b1;
    tick(); eng_bus.eng_done = 1'b0;
    tick(); tick();
    chk("ar_launch1_idx", int'(layer_idx), 1);
    tick();
    chk("ar_run_sel", int'(eng_bus.comp_sel), 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_sel", int'(eng_bus.comp_sel), 0);
    chk("ar_idx", int'(layer_idx), 0);
    chk("ar_swap", int'(buf_swap), 0);
    eng_bus.eng_done = 1'b1;
    tick();
    rst = 1'b1;
    tick(); eng_bus.eng_done = 1'b0;
    tick();
    chk("ar_late_done_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) dly_arr[i] = 3;
    run_layers(4, 1'b0);
    tick();

    // Full-length run: 16 conv layers, done one cycle after each start.
    for (int i = 0; i < 16; i++) begin
      types_arr[i] = 3'b001;
      dly_arr[i]   = 1;
    end
    run_layers(16, 1'b0);
    tick();

    // Randomized runs with occasional stray done pulses.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(16, 1);
      for (int i = 0; i < 16; i++) begin
        types_arr[i] = 3'($urandom_range(3, 1));
        dly_arr[i]   = $urandom_range(8, 1);
      end
      run_layers(n, 1'($urandom_range(1, 0)));
      eng_bus.eng_done = 1'b1; tick(); eng_bus.eng_done = 1'b0;
      tick();
      chk("rand_idle_busy", int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
